// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the APB requester and its wait timer.
// No logic; latency and backpressure are defined by the modules that import it.
// No backpressure.
package apb_pkg;

   localparam int APB_ADDR_W = 4;
   localparam int APB_DATA_W = 16;
   localparam int APB_WAIT_W = 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_master_states;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter with limit compare, used by apb_master under APB_MASTER_TIMEOUT_EN.
// expired is combinational from the registered count (same-cycle compare).
// No backpressure; the count is held once the limit is reached.
module apb_wait_timer
   import apb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  count_en,
   input  logic [APB_WAIT_W-1:0] limit,
   output logic                  expired
);

   logic [APB_WAIT_W-1:0] count;

   // Holding at the limit keeps the counter from wrapping if the owner lingers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == limit);

endmodule

// File: rtl/apb_master.sv
// APB requester: one outstanding single-beat read/write; APB_MASTER_TIMEOUT_EN adds an ACCESS timeout.
// Latency 3 cycles from accept to rsp_valid, plus one cycle per pready-low ACCESS cycle.
// req_ready only in IDLE; rsp_valid is a one-cycle strobe with no backpressure.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              pselx,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   apb_master_states state;
   apb_master_states state_nxt;

   logic accept;
   logic done;
   logic abort;
   logic expired;

   assign accept = req_valid && req_ready;
   assign done   = (state == ACCESS) && pready;
   assign abort  = (state == ACCESS) && !pready && expired;

   always_ff @(posedge pclk) begin
      if (prst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done || abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pselx     = (state == SETUP) || (state == ACCESS);
      penable   = (state == ACCESS);
      req_ready = (state == IDLE) && !prst;
   end

   // Bus fields load only on accept, so they stay frozen for the whole SETUP/ACCESS span.
   always_ff @(posedge pclk) begin
      if (prst) begin
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= done || abort;
         rsp_err   <= abort;
         if (accept) begin
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_wdata;
         end
         if (done && !pwrite) begin
            rsp_rdata <= prdata;
         end else if (abort) begin
            rsp_rdata <= '0;
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [APB_WAIT_W-1:0] WAIT_LIMIT = APB_WAIT_W'(TIMEOUT_CYCLES);

   apb_wait_timer u_wait_timer (
      .clk      (pclk),
      .rst      (prst),
      .clear    (state == SETUP),
      .count_en ((state == ACCESS) && !pready),
      .limit    (WAIT_LIMIT),
      .expired  (expired)
   );
`else
   logic unused_timeout;

   assign expired        = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
